// File: rtl/scan_pkg.sv
// rtl/scan_pkg.sv - shared FSM encoding and buffer depth for the register dump scanner
package scan_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_ISSUE = 2'd1;
  localparam state_t ST_DRAIN = 2'd2;

  localparam int FIFO_DEPTH = 2;

endpackage

// File: rtl/scan_fifo2.sv
// rtl/scan_fifo2.sv - two-entry output buffer; a write into a full buffer is accepted only alongside a read
module scan_fifo2
  import scan_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic [1:0]   count
);

  logic [FIFO_DEPTH-1:0][W-1:0] mem_q, mem_d;
  logic                         wr_ptr_q, wr_ptr_d;
  logic                         rd_ptr_q, rd_ptr_d;
  logic [1:0]                   cnt_q, cnt_d;
  logic                         do_wr, do_rd;

  assign do_rd   = rd_en && (cnt_q != 2'd0);
  assign do_wr   = wr_en && ((cnt_q != 2'(FIFO_DEPTH)) || do_rd);
  assign rd_data = mem_q[rd_ptr_q];
  assign count   = cnt_q;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      cnt_d    = 2'd0;
    end else begin
      if (do_wr) begin
        mem_d[wr_ptr_q] = wr_data;
        wr_ptr_d        = ~wr_ptr_q;
      end
      if (do_rd) rd_ptr_d = ~rd_ptr_q;
      cnt_d = cnt_q + 2'(do_wr) - 2'(do_rd);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_q    <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/reg_dump_scanner.sv
// rtl/reg_dump_scanner.sv - reads count consecutive registers from one source and streams {addr, data, last}
module reg_dump_scanner
  import scan_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10,
  parameter int NUM_CH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       abort,
  input  logic [$clog2(NUM_CH)-1:0]  ch_sel,
  input  logic [ADDR_W-1:0]          base_addr,
  input  logic [ADDR_W:0]            count,
  output logic [NUM_CH-1:0]          rd_en,
  output logic [ADDR_W-1:0]          rd_addr,
  input  logic [NUM_CH*DATA_W-1:0]   rd_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out_data,
  output logic [ADDR_W-1:0]          out_addr,
  output logic                       out_last,
  output logic                       busy,
  output logic                       done
);

  localparam int ENT_W = ADDR_W + DATA_W + 1;

  state_t                      state_q, state_d;
  logic [$clog2(NUM_CH)-1:0]   ch_q, ch_d;
  logic [ADDR_W-1:0]           addr_q, addr_d;
  logic [ADDR_W:0]             count_q, count_d;
  logic [ADDR_W:0]             issued_q, issued_d;
  logic                        inflight_q, inflight_d;
  logic [ADDR_W-1:0]           infl_addr_q, infl_addr_d;
  logic                        infl_last_q, infl_last_d;
  logic                        done_q, done_d;

  logic [1:0]                  fifo_cnt;
  logic [ENT_W-1:0]            fifo_head;
  logic [DATA_W-1:0]           rd_word;
  logic [2:0]                  pending;
  logic                        pop, issue, issue_last, last_hs;

  assign out_valid = (fifo_cnt != 2'd0);
  assign out_last  = out_valid && fifo_head[ENT_W-1];
  assign out_addr  = fifo_head[DATA_W +: ADDR_W];
  assign out_data  = fifo_head[DATA_W-1:0];
  assign pop       = out_valid && out_ready;
  assign last_hs   = pop && fifo_head[ENT_W-1];

  // Credit check counts this cycle's pop, so steady state is one word per cycle
  assign pending    = {1'b0, fifo_cnt} + {2'b00, inflight_q} - {2'b00, pop};
  assign issue      = (state_q == ST_ISSUE) && !abort && (pending < 3'd2);
  assign issue_last = ((issued_q + (ADDR_W+1)'(1)) == count_q);

  assign rd_en   = issue ? (NUM_CH'(1) << ch_q) : '0;
  assign rd_addr = addr_q;
  assign rd_word = rd_data[32'(ch_q) * DATA_W +: DATA_W];
  assign busy    = (state_q != ST_IDLE);
  assign done    = done_q;

  scan_fifo2 #(.W(ENT_W)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush   (abort && busy),
    .wr_en   (inflight_q && !abort),
    .wr_data ({infl_last_q, infl_addr_q, rd_word}),
    .rd_en   (pop),
    .rd_data (fifo_head),
    .count   (fifo_cnt)
  );

  always_comb begin
    state_d     = state_q;
    ch_d        = ch_q;
    addr_d      = addr_q;
    count_d     = count_q;
    issued_d    = issued_q;
    done_d      = 1'b0;
    inflight_d  = issue;
    infl_addr_d = issue ? addr_q : infl_addr_q;
    infl_last_d = issue ? issue_last : infl_last_q;
    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          if (count == '0) begin
            done_d = 1'b1;
          end else begin
            state_d  = ST_ISSUE;
            ch_d     = ch_sel;
            addr_d   = base_addr;
            count_d  = count;
            issued_d = '0;
          end
        end
      end
      ST_ISSUE: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (issue) begin
          addr_d   = addr_q + ADDR_W'(1);
          issued_d = issued_q + (ADDR_W+1)'(1);
          if (issue_last) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (last_hs) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      ch_q        <= '0;
      addr_q      <= '0;
      count_q     <= '0;
      issued_q    <= '0;
      inflight_q  <= 1'b0;
      infl_addr_q <= '0;
      infl_last_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ch_q        <= ch_d;
      addr_q      <= addr_d;
      count_q     <= count_d;
      issued_q    <= issued_d;
      inflight_q  <= inflight_d;
      infl_addr_q <= infl_addr_d;
      infl_last_q <= infl_last_d;
      done_q      <= done_d;
    end
  end

endmodule

// File: tb/tb_reg_dump_scanner.sv
// tb/tb_reg_dump_scanner.sv - scoreboard bench for reg_dump_scanner
module tb_reg_dump_scanner;

  typedef struct packed {
    logic        last;
    logic [9:0]  addr;
    logic [31:0] data;
  } word_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [0:0]  ch_sel = 1'b0;
  logic [9:0]  base_addr = '0;
  logic [10:0] count = '0;
  logic [1:0]  rd_en;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_data;
  logic [9:0]  out_addr;
  logic        out_last;
  logic        busy;
  logic        done;

  reg_dump_scanner #(.DATA_W(32), .ADDR_W(10), .NUM_CH(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .ch_sel    (ch_sel),
    .base_addr (base_addr),
    .count     (count),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_addr  (out_addr),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  int    n_checks = 0;
  int    n_fail   = 0;
  word_t exp_q[$];

  // Monitor-side reference model of the scanner's externally visible state
  logic       tb_busy = 1'b0;
  logic       done_arm = 1'b0;
  logic       new_arm;
  logic       tb_ch = 1'b0;
  logic [9:0] tb_next_addr = '0;
  int         tb_cnt = 0;
  int         tb_reads = 0;
  int         outstanding = 0;
  int         hs_cnt = 0;
  logic       stall_prev = 1'b0;
  word_t      stall_word;
  logic       hs, b0;
  word_t      e;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] src_val(input int k, input logic [9:0] a);
    return (k == 0) ? (32'h0000_0100 + 32'(a)) : (32'hA000_0000 + 32'(a));
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++)
      if (rd_en[k]) rd_data[k*32 +: 32] <= src_val(k, rd_addr);
  end

  always @(negedge clk) begin
    if (!rst) begin
      tb_busy     = 1'b0;
      done_arm    = 1'b0;
      stall_prev  = 1'b0;
      outstanding = 0;
    end else begin
      b0 = tb_busy;
      hs = out_valid && out_ready;
      check("busy", busy, tb_busy);
      check("done", done, done_arm);
      if (!tb_busy) check("valid_while_idle", out_valid, 1'b0);
      check("occupancy_le2", outstanding <= 2, 1'b1);
      if (stall_prev) begin
        check("stall_valid", out_valid, 1'b1);
        check("stall_hold", {out_last, out_addr, out_data}, stall_word);
      end
      if (rd_en != 2'b00) begin
        check("rd_en_onehot", rd_en, 2'b01 << tb_ch);
        check("rd_addr", rd_addr, tb_next_addr);
        check("rd_within_count", tb_reads < tb_cnt, 1'b1);
        tb_next_addr = tb_next_addr + 10'd1;
        tb_reads++;
      end
      outstanding = outstanding + ((rd_en != 2'b00) ? 1 : 0) - (hs ? 1 : 0);
      new_arm = 1'b0;
      if (hs) begin
        hs_cnt++;
        if (exp_q.size() == 0) begin
          check("unexpected_word", {out_addr, out_data}, 64'hDEAD);
        end else begin
          e = exp_q.pop_front();
          check("out_word", {out_last, out_addr, out_data}, e);
          if (e.last) begin
            new_arm = 1'b1;
            tb_busy = 1'b0;
          end
        end
      end
      if (abort && b0) begin
        tb_busy     = 1'b0;
        outstanding = 0;
      end
      if (start && !abort && !b0) begin
        if (count == 11'd0) begin
          new_arm = 1'b1;
        end else begin
          tb_busy      = 1'b1;
          tb_ch        = ch_sel[0];
          tb_next_addr = base_addr;
          tb_cnt       = int'(count);
          tb_reads     = 0;
          outstanding  = 0;
        end
      end
      stall_prev = out_valid && !out_ready && !abort;
      stall_word = {out_last, out_addr, out_data};
      done_arm   = new_arm;
    end
  end

  task automatic push_words(input int ch, input int base, input int cnt);
    word_t w;
    for (int i = 0; i < cnt; i++) begin
      w.last = (i == cnt - 1);
      w.addr = 10'(base + i);
      w.data = src_val(ch, w.addr);
      exp_q.push_back(w);
    end
  endtask

  task automatic launch(input int ch, input int base, input int cnt);
    hs_cnt = 0;
    @(posedge clk); #1;
    ch_sel    = 1'(ch);
    base_addr = 10'(base);
    count     = 11'(cnt);
    out_ready = 1'b1;
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_dump(input int ch, input int base, input int cnt,
                          input bit toggle, input bit lat, input bit poke);
    push_words(ch, base, cnt);
    launch(ch, base, cnt);
    if (lat) begin
      @(negedge clk); check("latency_c1_valid", out_valid, 1'b0);
      @(negedge clk); check("latency_c2_valid", out_valid, 1'b0);
      @(negedge clk); check("latency_first_valid", out_valid, 1'b1);
    end
    for (int c = 0; c < 400 && tb_busy; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (toggle) out_ready = ~out_ready;
      if (poke && c == 2) begin
        start     = 1'b1;
        base_addr = 10'h155;
        count     = 11'd3;
      end
    end
    check("dump_timeout", tb_busy, 1'b0);
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("queue_drained", exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    #2 rst = 1'b0;
    @(negedge clk); @(negedge clk);
    check("rst_rd_en", rd_en, 2'b00);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_last", out_last, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_rd_addr", rd_addr, 10'h0);
    check("rst_out_data", out_data, 32'h0);
    check("rst_out_addr", out_addr, 10'h0);
    @(posedge clk); #1 rst = 1'b1;

    run_dump(0, 10'h000, 4, 1'b0, 1'b1, 1'b0);
    run_dump(0, 10'h3FE, 4, 1'b0, 1'b0, 1'b1);
    run_dump(0, 10'h010, 8, 1'b1, 1'b0, 1'b0);
    run_dump(1, 10'h020, 2, 1'b0, 1'b0, 1'b0);
    run_dump(0, 10'h005, 0, 1'b0, 1'b0, 1'b0);

    // start together with abort is dropped
    @(posedge clk); #1;
    count = 11'd2; start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    repeat (3) @(posedge clk);
    #1 check("abort_with_start_busy", busy, 1'b0);

    // abort after the third word
    push_words(0, 10'h100, 8);
    launch(0, 10'h100, 8);
    for (int c = 0; c < 100 && hs_cnt < 3; c++) @(posedge clk);
    #1;
    check("abort_reached_3", hs_cnt, 3);
    abort = 1'b1; out_ready = 1'b0;
    exp_q.delete();
    @(posedge clk); #1;
    abort = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    check("abort_busy", busy, 1'b0);
    check("abort_valid", out_valid, 1'b0);
    check("abort_done", done, 1'b0);
    repeat (3) @(posedge clk);

    // asynchronous reset in the middle of a dump
    push_words(0, 10'h200, 8);
    launch(0, 10'h200, 8);
    for (int c = 0; c < 100 && hs_cnt < 2; c++) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check("mid_rst_rd_en", rd_en, 2'b00);
    check("mid_rst_out_valid", out_valid, 1'b0);
    check("mid_rst_out_last", out_last, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_done", done, 1'b0);
    check("mid_rst_rd_addr", rd_addr, 10'h0);
    check("mid_rst_out_data", out_data, 32'h0);
    check("mid_rst_out_addr", out_addr, 10'h0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    run_dump(0, 10'h000, 4, 1'b0, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
